// File: rtl/ram_copy_engine.sv
// Copy/fill DMA-style initiator for a single-port synchronous RAM (1-cycle read latency).
// Sequences RD/WR word pairs for copy, one write per cycle for fill, with abort at word boundaries.
module ram_copy_engine #(
  parameter int N_DATA      = 64,
  parameter int N_DATA_BYTE = 4,
  localparam int N_ADDRBIT  = $clog2(N_DATA)
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_cmd_valid,
  output logic                       o_cmd_ready,
  input  logic                       i_cmd_fill,
  input  logic [N_ADDRBIT-1:0]       i_cmd_src,
  input  logic [N_ADDRBIT-1:0]       i_cmd_dst,
  input  logic [N_ADDRBIT:0]         i_cmd_len,
  input  logic [N_DATA_BYTE*8-1:0]   i_cmd_pattern,
  input  logic                       i_abort,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_aborted,
  output logic [N_ADDRBIT:0]         o_count,
  output logic                       o_ram_en,
  output logic [N_ADDRBIT-1:0]       o_ram_addr,
  output logic [N_DATA_BYTE-1:0]     o_ram_wen,
  output logic [N_DATA_BYTE*8-1:0]   o_ram_wdata,
  input  logic [N_DATA_BYTE*8-1:0]   i_ram_rdata
);

  localparam int W = N_DATA_BYTE * 8;
  localparam logic [N_ADDRBIT:0] LEN_MAX = (N_ADDRBIT + 1)'(N_DATA);
  localparam logic [N_ADDRBIT:0] ONE     = (N_ADDRBIT + 1)'(1);

  typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_FILL, ST_DONE} state_t;

  state_t                 state_reg, state_next;
  logic [N_ADDRBIT-1:0]   src_reg, src_next;
  logic [N_ADDRBIT-1:0]   dst_reg, dst_next;
  logic [N_ADDRBIT:0]     len_reg, len_next;
  logic [W-1:0]           pattern_reg, pattern_next;
  logic [N_ADDRBIT:0]     count_reg, count_next;
  logic                   aborted_reg, aborted_next;
  logic                   ram_en_reg, ram_en_next;
  logic [N_ADDRBIT-1:0]   ram_addr_reg, ram_addr_next;
  logic [N_DATA_BYTE-1:0] ram_wen_reg, ram_wen_next;
  logic [W-1:0]           ram_wdata_reg, ram_wdata_next;
  logic                   wr_pass_reg, wr_pass_next;

  logic                   abort_now;
  logic [N_ADDRBIT:0]     len_sat;
  logic [N_ADDRBIT:0]     count_inc;

  assign abort_now = i_abort && ((state_reg == ST_RD) || (state_reg == ST_FILL));
  assign len_sat   = (i_cmd_len > LEN_MAX) ? LEN_MAX : i_cmd_len;
  assign count_inc = count_reg + ONE;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_reg     <= ST_IDLE;
      src_reg       <= '0;
      dst_reg       <= '0;
      len_reg       <= '0;
      pattern_reg   <= '0;
      count_reg     <= '0;
      aborted_reg   <= 1'b0;
      ram_en_reg    <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wen_reg   <= '0;
      ram_wdata_reg <= '0;
      wr_pass_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      src_reg       <= src_next;
      dst_reg       <= dst_next;
      len_reg       <= len_next;
      pattern_reg   <= pattern_next;
      count_reg     <= count_next;
      aborted_reg   <= aborted_next;
      ram_en_reg    <= ram_en_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wen_reg   <= ram_wen_next;
      ram_wdata_reg <= ram_wdata_next;
      wr_pass_reg   <= wr_pass_next;
    end
  end

  // The RAM access for the next cycle is decided here and registered with the state.
  always_comb begin
    state_next     = state_reg;
    src_next       = src_reg;
    dst_next       = dst_reg;
    len_next       = len_reg;
    pattern_next   = pattern_reg;
    count_next     = count_reg;
    aborted_next   = aborted_reg;
    ram_en_next    = 1'b0;
    ram_addr_next  = '0;
    ram_wen_next   = '0;
    ram_wdata_next = '0;
    wr_pass_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (i_cmd_valid) begin
          src_next     = i_cmd_src;
          dst_next     = i_cmd_dst;
          len_next     = len_sat;
          pattern_next = i_cmd_pattern;
          count_next   = '0;
          aborted_next = 1'b0;
          if (len_sat == '0) begin
            state_next = ST_DONE;
          end else if (i_cmd_fill) begin
            state_next     = ST_FILL;
            ram_en_next    = 1'b1;
            ram_addr_next  = i_cmd_dst;
            ram_wen_next   = '1;
            ram_wdata_next = i_cmd_pattern;
          end else begin
            state_next    = ST_RD;
            ram_en_next   = 1'b1;
            ram_addr_next = i_cmd_src;
          end
        end
      end
      ST_RD: begin
        if (abort_now) begin
          state_next   = ST_DONE;
          aborted_next = 1'b1;
        end else begin
          state_next    = ST_WR;
          ram_en_next   = 1'b1;
          ram_addr_next = dst_reg + count_reg[N_ADDRBIT-1:0];
          ram_wen_next  = '1;
          wr_pass_next  = 1'b1;
        end
      end
      ST_WR: begin
        count_next = count_inc;
        if (count_inc == len_reg) begin
          state_next = ST_DONE;
        end else begin
          state_next    = ST_RD;
          ram_en_next   = 1'b1;
          ram_addr_next = src_reg + count_inc[N_ADDRBIT-1:0];
        end
      end
      ST_FILL: begin
        if (abort_now) begin
          state_next   = ST_DONE;
          aborted_next = 1'b1;
        end else begin
          count_next = count_inc;
          if (count_inc == len_reg) begin
            state_next = ST_DONE;
          end else begin
            ram_en_next    = 1'b1;
            ram_addr_next  = dst_reg + count_inc[N_ADDRBIT-1:0];
            ram_wen_next   = '1;
            ram_wdata_next = pattern_reg;
          end
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign o_cmd_ready = (state_reg == ST_IDLE);
  assign o_busy      = (state_reg != ST_IDLE);
  assign o_done      = (state_reg == ST_DONE);
  assign o_aborted   = aborted_reg;
  assign o_count     = count_reg;

  // Abort must cancel the access of the very cycle it is seen in, so it gates the
  // registered strobes; write data in WR comes straight from the read one cycle earlier.
  assign o_ram_en    = ram_en_reg && !abort_now;
  assign o_ram_addr  = ram_addr_reg;
  assign o_ram_wen   = abort_now ? '0 : ram_wen_reg;
  assign o_ram_wdata = wr_pass_reg ? i_ram_rdata : ram_wdata_reg;

endmodule

// File: tb/tb_ram_copy_engine.sv
// Directed bench for ram_copy_engine: RAM model, shadow memory, latency/count/abort/reset checks.
module tb_ram_copy_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_fill;
  logic [5:0]  cmd_src, cmd_dst;
  logic [6:0]  cmd_len;
  logic [31:0] cmd_pattern;
  logic        abort, busy, done, aborted;
  logic [6:0]  count;
  logic        ram_en;
  logic [5:0]  ram_addr;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [64];
  logic [31:0] exp_mem [64];
  logic        pre_we = 1'b0;
  logic [5:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;
  int          wr_cnt = 0;
  int          en_cnt = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  typedef struct {
    bit          fill;
    int          src;
    int          dst;
    int          len;
    logic [31:0] pat;
    int          lat;
    int          cnt;
  } vec_t;
  vec_t vecs[8];

  always #5 clk = ~clk;

  ram_copy_engine #(.N_DATA(64), .N_DATA_BYTE(4)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_fill(cmd_fill),
    .i_cmd_src(cmd_src), .i_cmd_dst(cmd_dst), .i_cmd_len(cmd_len),
    .i_cmd_pattern(cmd_pattern), .i_abort(abort),
    .o_busy(busy), .o_done(done), .o_aborted(aborted), .o_count(count),
    .o_ram_en(ram_en), .o_ram_addr(ram_addr), .o_ram_wen(ram_wen),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata)
  );

  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= mem[ram_addr];
    end
    if (ram_en) en_cnt <= en_cnt + 1;
    if (ram_en && ram_wen != 4'h0) wr_cnt <= wr_cnt + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic poke(input int a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = 6'(a); pre_data = d;
    exp_mem[a] = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic preload(input logic [31:0] base);
    for (int i = 0; i < 64; i++) poke(i, base + 32'(i));
  endtask

  task automatic check_mem(input string name);
    int bad = 0;
    for (int i = 0; i < 64; i++) if (mem[i] !== exp_mem[i]) bad++;
    check(name, 64'(bad), 64'd0);
  endtask

  task automatic run_cmd(input string name, input bit fill, input int src, input int dst,
                         input int len, input logic [31:0] pat, input int exp_lat,
                         input int exp_cnt, input int abort_at, input bit exp_abt);
    int  base_w, base_e, lat;
    bit  got;
    @(negedge clk);
    check({name, ".ready"}, 64'(cmd_ready), 64'd1);
    base_w = wr_cnt; base_e = en_cnt;
    cmd_fill = fill; cmd_src = 6'(src); cmd_dst = 6'(dst);
    cmd_len = 7'(len); cmd_pattern = pat; cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_fill = ~fill; cmd_src = ~6'(src); cmd_dst = ~6'(dst);
    cmd_len = 7'($urandom_range(0, 127)); cmd_pattern = ~pat;
    lat = 0; got = 0;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      lat++;
      if (abort_at == lat) begin
        abort = 1'b1;
        #1;
        check({name, ".abort_en"}, 64'(ram_en), 64'd0);
      end else begin
        abort = 1'b0;
      end
      if (done) got = 1;
    end
    abort = 1'b0;
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no done expected done", name);
    end
    check({name, ".lat"}, 64'(lat), 64'(exp_lat));
    check({name, ".count"}, 64'(count), 64'(exp_cnt));
    check({name, ".aborted"}, 64'(aborted), 64'(exp_abt));
    check({name, ".ready_done"}, 64'(cmd_ready), 64'd0);
    check({name, ".busy_done"}, 64'(busy), 64'd1);
    check({name, ".writes"}, 64'(wr_cnt - base_w), 64'(exp_cnt));
    check({name, ".accesses"}, 64'(en_cnt - base_e), fill ? 64'(exp_cnt) : 64'(2 * exp_cnt));
    for (int k = 0; k < exp_cnt; k++)
      exp_mem[(dst + k) % 64] = fill ? pat : exp_mem[(src + k) % 64];
    check_mem({name, ".mem"});
    @(negedge clk);
    check({name, ".ready_after"}, 64'(cmd_ready), 64'd1);
    check({name, ".count_hold"}, 64'(count), 64'(exp_cnt));
    check({name, ".aborted_hold"}, 64'(aborted), 64'(exp_abt));
    $display("cmd %s fill=%0d src=%0d dst=%0d len=%0d lat=%0d count=%0d aborted=%0d",
             name, fill, src, dst, len, lat, count, aborted);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //           fill src dst len pattern        lat  cnt
    vecs[0] = '{1'b0,  0,  8,   4, 32'h0,         9,   4};
    vecs[1] = '{1'b1,  0, 62,   3, 32'hA5A5A5A5,  4,   3};
    vecs[2] = '{1'b0,  5, 20,   0, 32'h0,         1,   0};
    vecs[3] = '{1'b1,  0,  5,   1, 32'h12345678,  2,   1};
    vecs[4] = '{1'b0,  8, 10,   4, 32'h0,         9,   4};
    vecs[5] = '{1'b0, 60,  2,   6, 32'h0,        13,   6};
    vecs[6] = '{1'b1,  0,  0, 100, 32'h5A5A0F0F, 65,  64};
    vecs[7] = '{1'b0,  3,  3,  64, 32'h0,       129,  64};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_fill = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_pattern = '0; abort = 1'b0;
    preload(32'hC0DE0000);
    poke(0, 32'h11); poke(1, 32'h22); poke(2, 32'h33); poke(3, 32'h44);
    @(negedge clk);
    check("rst.ready", 64'(cmd_ready), 64'd1);
    check("rst.busy", 64'(busy), 64'd0);
    check("rst.done", 64'(done), 64'd0);
    check("rst.aborted", 64'(aborted), 64'd0);
    check("rst.count", 64'(count), 64'd0);
    check("rst.ram_bus", {27'd0, ram_en, ram_addr, ram_wen, ram_wdata}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 8; v++)
      run_cmd($sformatf("vec%0d", v), vecs[v].fill, vecs[v].src, vecs[v].dst, vecs[v].len,
              vecs[v].pat, vecs[v].lat, vecs[v].cnt, 0, 1'b0);

    // abort during the 3rd RD cycle of an 8-word copy, then during the 3rd FILL cycle
    preload(32'h7E570000);
    run_cmd("abort_copy", 1'b0, 0, 32, 8, 32'h0, 6, 2, 5, 1'b1);
    run_cmd("abort_fill", 1'b1, 0, 16, 5, 32'hDEADBEEF, 4, 2, 3, 1'b1);

    // asynchronous reset during the second FILL cycle
    @(negedge clk);
    cmd_fill = 1'b1; cmd_dst = 6'd40; cmd_len = 7'd10; cmd_pattern = 32'hC3C3C3C3;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rstmid.first_addr", {57'd0, ram_en, ram_addr}, {57'd0, 1'b1, 6'd40});
    @(negedge clk);
    check("rstmid.second_addr", {57'd0, ram_en, ram_addr}, {57'd0, 1'b1, 6'd41});
    rst_n = 1'b0;
    #1;
    check("rstmid.ram_en", 64'(ram_en), 64'd0);
    check("rstmid.ram_bus", {27'd0, ram_en, ram_addr, ram_wen, ram_wdata}, 64'd0);
    check("rstmid.busy", 64'(busy), 64'd0);
    check("rstmid.count", 64'(count), 64'd0);
    check("rstmid.ready", 64'(cmd_ready), 64'd1);
    exp_mem[40] = 32'hC3C3C3C3;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid.ready_after", 64'(cmd_ready), 64'd1);
    check("rstmid.done_after", 64'(done), 64'd0);
    check_mem("rstmid.mem");
    $display("cmd rstmid fill=1 dst=40 len=10 interrupted by reset");
    run_cmd("post_rst_copy", 1'b0, 40, 50, 3, 32'h0, 7, 3, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_copy_engine.md
Name: ram_copy_engine

Overview:
- Initiator for the single-port synchronous RAM interface: en, addr, per-byte wen, wdata, and rdata with 1-cycle registered read latency.
- Accepts copy or fill commands over a valid/ready handshake and sequences word accesses on one RAM port.
- Used for buffer relocation, memory clearing and pattern initialisation without a CPU.

Parameters:
- N_DATA, 64, RAM depth in words; power of two.
- N_DATA_BYTE, 4, bytes per word; word width is N_DATA_BYTE*8.
- N_ADDRBIT, $clog2(N_DATA), local, address width.

Ports:
- i_clock  in  1  clock; all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_cmd_valid  in  1  command valid.
- o_cmd_ready  out  1  engine idle; command accepted when valid&ready.
- i_cmd_fill  in  1  1=fill, 0=copy.
- i_cmd_src  in  N_ADDRBIT  copy source start word address; ignored for fill.
- i_cmd_dst  in  N_ADDRBIT  destination start word address.
- i_cmd_len  in  N_ADDRBIT+1  word count, 0..N_DATA; values above N_DATA saturate to N_DATA.
- i_cmd_pattern  in  N_DATA_BYTE*8  fill word.
- i_abort  in  1  stop at next word boundary.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle completion pulse.
- o_aborted  out  1  valid with o_done; 1 if ended by abort.
- o_count  out  N_ADDRBIT+1  words written by the current or last command.
- o_ram_en  out  1  RAM enable.
- o_ram_addr  out  N_ADDRBIT  RAM word address.
- o_ram_wen  out  N_DATA_BYTE  byte write enables.
- o_ram_wdata  out  N_DATA_BYTE*8  write data.
- i_ram_rdata  in  N_DATA_BYTE*8  RAM read data, valid the cycle after a read access.

Behaviour:
- Reset values (i_reset low): state IDLE, o_cmd_ready=1, and all other outputs 0, including o_count. Reset takes effect asynchronously: a reset mid-command drops o_ram_en immediately, and no partial access is issued after it.
- States: IDLE, RD, WR, FILL, DONE.
- IDLE: o_cmd_ready=1. On accept, latch src, dst, len (saturated), pattern and mode, and clear o_count to 0.
  - len==0: go to DONE.
  - fill: go to FILL.
  - copy: go to RD.
- All RAM outputs are registered. Every RAM access cycle drives a complete, consistent en/addr/wen/wdata set. o_ram_en=0 in IDLE and DONE.
- RD: o_ram_en=1, o_ram_wen=0, o_ram_addr=src+k (mod N_DATA). Next state is WR.
- WR: o_ram_en=1, o_ram_wen all ones, o_ram_addr=dst+k, o_ram_wdata=i_ram_rdata (the read issued in RD). Then o_count++ and k++.
  - k==len: go to DONE.
  - otherwise: go to RD.
- Copy throughput is 2 cycles per word. Copy runs in ascending order; overlapping regions with dst>src propagate data forward (defined behaviour, not corrected).
- FILL: o_ram_en=1, wen all ones, addr=dst+k, wdata=pattern, o_count++. Goes to DONE after len words. Throughput is 1 word per cycle.
- Address wrap: src+k and dst+k wrap modulo N_DATA.
- Latency: for a command accepted at cycle T, the first RAM access is at T+1. o_done pulses at:
  - copy: T+1+2*len
  - fill: T+1+len
  - len==0: T+1
- DONE: lasts one cycle with o_done=1, then returns to IDLE. o_cmd_ready=0 during DONE; the next command can be accepted the cycle after o_done. Back-to-back commands with valid held are therefore accepted every len+2 cycles (fill).
- o_busy=1 from the cycle after accept through DONE.
- Abort: i_abort is sampled in RD and FILL.
  - If high, no access is issued that cycle; go to DONE with o_aborted=1.
  - In WR the write always completes; abort is honoured at the following RD.
  - o_count reports the words actually written.
  - i_abort in IDLE is ignored.
- o_count and o_aborted hold until the next accept.
- Command inputs are sampled only at accept; later changes have no effect.

Test Plan:
- Copy: RAM[0..3]=11,22,33,44; cmd copy src=0 dst=8 len=4 -> alternating RD/WR, done at T+9, RAM[8..11]=11,22,33,44, o_count=4, o_aborted=0.
- Fill with wrap: dst=62 len=3 pattern=0xA5A5A5A5 -> writes to addr 62, 63, 0 on consecutive cycles, done at T+4, RAM[1] unchanged.
- len==0 -> no o_ram_en assertion, o_done at T+1, o_count=0.
- len=100 (N_DATA=64) fill -> exactly 64 writes, o_count=64.
- Abort: copy len=8, i_abort pulsed during the 3rd RD cycle -> 2 words written, o_done with o_aborted=1, o_count=2, destination words 3..8 untouched.
- Reset mid-fill: i_reset low during the 2nd FILL cycle -> o_ram_en=0 in the same cycle, outputs zero, o_cmd_ready=1 after release. A new copy command after release completes correctly.
